// File: rtl/bram_arbiter_pkg.sv
// Shared arbiter types: FSM states, grant encoding and the request payload.
package bram_arbiter_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACT_I = 2'd1,
    ST_ACT_D = 2'd2,
    ST_ERR   = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } mem_req_t;

  // Unsigned half-open window test: base <= addr < top.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] base,
                                     input logic [ADDR_W-1:0] top);
    return (addr >= base) && (addr < top);
  endfunction
endpackage

// File: rtl/configure.sv
// Platform memory map shared by the core's memory-side blocks.
package configure;
  localparam logic [31:0] bram_base_addr = 32'h0000_0000;
  localparam logic [31:0] bram_top_addr  = 32'h0010_0000;
endpackage

// File: rtl/bram_arbiter_if.sv
// Fetch, load/store and BRAM-side signals of the BRAM port arbiter.
interface bram_arbiter_if;
  import bram_arbiter_pkg::*;

  logic              imem_valid;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rdata;
  logic              imem_ready;

  logic              dmem_valid;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [STRB_W-1:0] dmem_wstrb;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ready;

  logic              bram_valid;
  logic              bram_instr;
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_wdata;
  logic [STRB_W-1:0] bram_wstrb;
  logic [DATA_W-1:0] bram_rdata;
  logic              bram_ready;

  // Arbiter side.
  modport slave (
    input  imem_valid, imem_addr,
    output imem_rdata, imem_ready,
    input  dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ready,
    output bram_valid, bram_instr, bram_addr, bram_wdata, bram_wstrb,
    input  bram_rdata, bram_ready
  );

  // Core and BRAM environment side.
  modport master (
    output imem_valid, imem_addr,
    input  imem_rdata, imem_ready,
    output dmem_valid, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ready,
    input  bram_valid, bram_instr, bram_addr, bram_wdata, bram_wstrb,
    output bram_rdata, bram_ready
  );
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter giving fetch and load/store one outstanding BRAM access
// at a time; out-of-window requests get a local zero-data response.
module bram_arbiter
  import bram_arbiter_pkg::*;
#(
  parameter logic [ADDR_W-1:0] base_addr = configure::bram_base_addr,
  parameter logic [ADDR_W-1:0] top_addr  = configure::bram_top_addr
) (
  input logic           clock,
  input logic           reset,
  bram_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;
  grant_e     last_grant_q, last_grant_d;
  logic       i_pend_q, i_pend_d;
  logic       d_pend_q, d_pend_d;
  mem_req_t   i_req_q, i_req_d;
  mem_req_t   d_req_q, d_req_d;
  logic       bram_valid_q, bram_valid_d;
  logic       bram_instr_q, bram_instr_d;
  mem_req_t   bram_req_q, bram_req_d;

  logic       done_c;
  grant_e     grant_c;
  mem_req_t   sel_req_c;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GRANT_I;
      i_pend_q     <= 1'b0;
      d_pend_q     <= 1'b0;
      i_req_q      <= '0;
      d_req_q      <= '0;
      bram_valid_q <= 1'b0;
      bram_instr_q <= 1'b0;
      bram_req_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      i_pend_q     <= i_pend_d;
      d_pend_q     <= d_pend_d;
      i_req_q      <= i_req_d;
      d_req_q      <= d_req_d;
      bram_valid_q <= bram_valid_d;
      bram_instr_q <= bram_instr_d;
      bram_req_q   <= bram_req_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    i_pend_d     = i_pend_q;
    d_pend_d     = d_pend_q;
    i_req_d      = i_req_q;
    d_req_d      = d_req_q;
    bram_valid_d = 1'b0;
    bram_instr_d = bram_instr_q;
    bram_req_d   = bram_req_q;
    done_c       = 1'b0;
    grant_c      = GRANT_I;
    sel_req_c    = '0;

    unique case (state_q)
      ST_ACT_I, ST_ACT_D: done_c = bus.bram_ready;
      ST_ERR:             done_c = 1'b1;
      default:            done_c = 1'b0;
    endcase

    // Capture only into an empty slot; pulses on an outstanding port are dropped.
    if (bus.imem_valid && !i_pend_q) begin
      i_pend_d = 1'b1;
      i_req_d  = '{addr: bus.imem_addr, wdata: '0, wstrb: '0};
    end
    if (bus.dmem_valid && !d_pend_q) begin
      d_pend_d = 1'b1;
      d_req_d  = '{addr: bus.dmem_addr, wdata: bus.dmem_wdata, wstrb: bus.dmem_wstrb};
    end

    // The slot of the port being answered retires in its completion cycle.
    if (done_c) begin
      if (last_grant_q == GRANT_I) i_pend_d = 1'b0;
      else                         d_pend_d = 1'b0;
    end

    // Post-update pending flags are exactly this cycle's candidates.
    if ((state_q == ST_IDLE) || done_c) begin
      state_d = ST_IDLE;
      if (i_pend_d || d_pend_d) begin
        if (i_pend_d && d_pend_d)
          grant_c = (last_grant_q == GRANT_I) ? GRANT_D : GRANT_I;
        else
          grant_c = d_pend_d ? GRANT_D : GRANT_I;
        last_grant_d = grant_c;
        sel_req_c    = (grant_c == GRANT_D) ? d_req_d : i_req_d;
        if (in_window(sel_req_c.addr, base_addr, top_addr)) begin
          bram_valid_d = 1'b1;
          bram_instr_d = (grant_c == GRANT_I);
          bram_req_d   = sel_req_c;
          state_d      = (grant_c == GRANT_I) ? ST_ACT_I : ST_ACT_D;
        end else begin
          state_d = ST_ERR;
        end
      end
    end
  end

  // Completions are combinational so the requester sees them with bram_ready.
  assign bus.imem_ready = ((state_q == ST_ACT_I) && bus.bram_ready) ||
                          ((state_q == ST_ERR) && (last_grant_q == GRANT_I));
  assign bus.dmem_ready = ((state_q == ST_ACT_D) && bus.bram_ready) ||
                          ((state_q == ST_ERR) && (last_grant_q == GRANT_D));
  assign bus.imem_rdata = ((state_q == ST_ACT_I) && bus.bram_ready) ? bus.bram_rdata : '0;
  assign bus.dmem_rdata = ((state_q == ST_ACT_D) && bus.bram_ready) ? bus.bram_rdata : '0;

  assign bus.bram_valid = bram_valid_q;
  assign bus.bram_instr = bram_instr_q;
  assign bus.bram_addr  = bram_req_q.addr;
  assign bus.bram_wdata = bram_req_q.wdata;
  assign bus.bram_wstrb = bram_req_q.wstrb;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: directed stimulus, BRAM responder model,
// separate monitors for backend requests and port completions.
module tb_bram_arbiter;

  typedef struct {
    bit          port;   // 0 = fetch, 1 = data
    logic [31:0] rdata;
    int          cyc;
  } resp_t;

  typedef struct {
    bit          instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          cyc;
  } breq_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   bram_lat = 2;

  resp_t rq[$];
  breq_t bq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bram_arbiter_if bus ();

  bram_arbiter dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_b(input bit instr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int c);
    breq_t e;
    e.instr = instr; e.addr = addr; e.wdata = wdata; e.wstrb = wstrb; e.cyc = c;
    bq.push_back(e);
  endtask

  task automatic push_r(input bit port, input logic [31:0] rdata, input int c);
    resp_t e;
    e.port = port; e.rdata = rdata; e.cyc = c;
    rq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.imem_valid = 1'b0;
    bus.dmem_valid = 1'b0;
  endtask

  task automatic drive_i(input logic [31:0] a);
    bus.imem_valid = 1'b1;
    bus.imem_addr  = a;
  endtask

  task automatic drive_d(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    bus.dmem_valid = 1'b1;
    bus.dmem_addr  = a;
    bus.dmem_wdata = wd;
    bus.dmem_wstrb = ws;
  endtask

  task automatic check_outs_zero(input string p);
    chk({p, "_bram_valid"}, 32'(bus.bram_valid), 32'd0);
    chk({p, "_bram_instr"}, 32'(bus.bram_instr), 32'd0);
    chk({p, "_bram_addr"},  bus.bram_addr,       32'd0);
    chk({p, "_bram_wdata"}, bus.bram_wdata,      32'd0);
    chk({p, "_bram_wstrb"}, 32'(bus.bram_wstrb), 32'd0);
    chk({p, "_imem_ready"}, 32'(bus.imem_ready), 32'd0);
    chk({p, "_dmem_ready"}, 32'(bus.dmem_ready), 32'd0);
    chk({p, "_imem_rdata"}, bus.imem_rdata,      32'd0);
    chk({p, "_dmem_rdata"}, bus.dmem_rdata,      32'd0);
  endtask

  // BRAM model: answers each accepted request bram_lat cycles later.
  initial begin
    int lat;
    logic [31:0] a;
    bus.bram_ready = 1'b0;
    bus.bram_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      if (bus.bram_valid === 1'b1) begin
        lat = bram_lat;
        a   = bus.bram_addr;
        repeat (lat) @(posedge clk);
        #1;
        bus.bram_ready = 1'b1;
        bus.bram_rdata = word(a);
        @(posedge clk);
        #1;
        bus.bram_ready = 1'b0;
        bus.bram_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Backend request monitor.
  always @(negedge clk) begin
    breq_t e;
    if (bus.bram_valid === 1'b1) begin
      if (bq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bram_unexpected actual=addr %h required=no access (cycle %0d)", bus.bram_addr, cyc);
      end else begin
        e = bq.pop_front();
        chk("bram_instr", 32'(bus.bram_instr), 32'(e.instr));
        chk("bram_addr",  bus.bram_addr,       e.addr);
        chk("bram_wdata", bus.bram_wdata,      e.wdata);
        chk("bram_wstrb", 32'(bus.bram_wstrb), 32'(e.wstrb));
        chk("bram_cycle", 32'(cyc),            32'(e.cyc));
      end
    end
  end

  task automatic got(input bit port, input logic [31:0] rdata);
    resp_t e;
    if (rq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ready actual=port %0d rdata %h required=none (cycle %0d)", port, rdata, cyc);
    end else begin
      e = rq.pop_front();
      chk("resp_port",  32'(port), 32'(e.port));
      chk("resp_rdata", rdata,     e.rdata);
      chk("resp_cycle", 32'(cyc),  32'(e.cyc));
    end
  endtask

  // Completion monitor.
  always @(negedge clk) begin
    if (bus.imem_ready === 1'b1 && bus.dmem_ready === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL dual_ready actual=both required=at most one (cycle %0d)", cyc);
    end
    if (bus.imem_ready === 1'b1) got(1'b0, bus.imem_rdata);
    if (bus.dmem_ready === 1'b1) got(1'b1, bus.dmem_rdata);
  end

  initial begin
    int t;
    int n;
    bus.imem_valid = 1'b0;
    bus.imem_addr  = '0;
    bus.dmem_valid = 1'b0;
    bus.dmem_addr  = '0;
    bus.dmem_wdata = '0;
    bus.dmem_wstrb = '0;

    repeat (2) @(posedge clk);
    #1;
    check_outs_zero("reset");
    rst_n = 1'b1;
    step();

    // Tie right after reset: data first, fetch with zero bubble after it.
    step(); t = cyc;
    drive_i(32'h0);
    drive_d(32'h200, 32'hDEAD_BEEF, 4'hF);
    push_b(1'b0, 32'h200, 32'hDEAD_BEEF, 4'hF, t + 1);
    push_r(1'b1, word(32'h200), t + 3);
    push_b(1'b1, 32'h0, 32'h0, 4'h0, t + 4);
    push_r(1'b0, word(32'h0), t + 6);
    step(); idle_inputs();
    repeat (8) step();

    // Single fetch, BRAM answers two cycles after the request.
    step(); t = cyc;
    drive_i(32'h100);
    push_b(1'b1, 32'h100, 32'h0, 4'h0, t + 1);
    push_r(1'b0, word(32'h100), t + 3);
    step(); idle_inputs();
    repeat (6) step();

    // Continuous contention: 8 accesses alternating D, I, D, I ...
    bram_lat = 1;
    for (int j = 0; j < 8; j++) begin
      logic [31:0] a;
      a = (j % 2 == 0) ? 32'h1000 + 32'(4 * j) : 32'h2000 + 32'(4 * j);
      if (j == 4) push_b(1'b0, a, 32'h1234_5678, 4'h3, 0);
      else        push_b(j % 2 == 1, a, 32'h0, 4'h0, 0);
      bq[bq.size() - 1].cyc = 0;
    end
    step(); t = cyc;
    for (int j = 0; j < 8; j++) begin
      bq[bq.size() - 8 + j].cyc = t + 1 + 2 * j;
      push_r(j % 2 == 0, word(bq[bq.size() - 8 + j].addr), t + 2 + 2 * j);
    end
    drive_i(32'h2004);
    drive_d(32'h1000, 32'h0, 4'h0);
    for (int o = 1; o <= 16; o++) begin
      step(); idle_inputs();
      if (o >= 3 && (o - 3) % 2 == 0 && (o - 3) / 2 <= 5) begin
        int j;
        j = (o - 3) / 2 + 2;
        if (j % 2 == 1)  drive_i(32'h2000 + 32'(4 * j));
        else if (j == 4) drive_d(32'h1000 + 32'(4 * j), 32'h1234_5678, 4'h3);
        else             drive_d(32'h1000 + 32'(4 * j), 32'h0, 4'h0);
      end
    end
    repeat (4) step();

    // Out-of-window load answered locally one cycle later.
    bram_lat = 2;
    step(); t = cyc;
    drive_d(32'h0100_0000, 32'h0, 4'h0);
    push_r(1'b1, 32'h0, t + 1);
    step(); idle_inputs();
    repeat (4) step();

    // Window boundaries: last word served, first beyond errors on both ports.
    step(); t = cyc;
    drive_i(32'h000F_FFFC);
    push_b(1'b1, 32'h000F_FFFC, 32'h0, 4'h0, t + 1);
    push_r(1'b0, word(32'h000F_FFFC), t + 3);
    step(); idle_inputs();
    repeat (5) step();
    step(); t = cyc;
    drive_d(32'h0010_0000, 32'h0, 4'h0);
    push_r(1'b1, 32'h0, t + 1);
    step(); idle_inputs();
    repeat (3) step();
    step(); t = cyc;
    drive_i(32'h0010_0000);
    push_r(1'b0, 32'h0, t + 1);
    step(); idle_inputs();
    repeat (3) step();

    // Reset while a store is active; the late bram_ready must be ignored.
    bram_lat = 3;
    step(); t = cyc;
    drive_d(32'h300, 32'hCAFE_F00D, 4'hC);
    push_b(1'b0, 32'h300, 32'hCAFE_F00D, 4'hC, t + 1);
    step(); idle_inputs();
    step();
    rst_n = 1'b0;
    #1;
    check_outs_zero("rst_mid");
    step();
    rst_n = 1'b1;
    step();
    bram_lat = 2;
    @(negedge clk);
    chk("stray_dmem_ready", 32'(bus.dmem_ready), 32'd0);
    chk("stray_state_idle_bram_valid", 32'(bus.bram_valid), 32'd0);
    step();
    // Tie after the mid-access reset: last_grant back to fetch, so data wins.
    step(); t = cyc;
    drive_i(32'h40);
    drive_d(32'h44, 32'h0, 4'h0);
    push_b(1'b0, 32'h44, 32'h0, 4'h0, t + 1);
    push_r(1'b1, word(32'h44), t + 3);
    push_b(1'b1, 32'h40, 32'h0, 4'h0, t + 4);
    push_r(1'b0, word(32'h40), t + 6);
    step(); idle_inputs();

    n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 50) begin
      step();
      n++;
    end
    repeat (3) step();
    chk("resp_queue_drained", 32'(rq.size()), 32'd0);
    chk("bram_queue_drained", 32'(bq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Two-port arbiter sharing the single BRAM memory port between the instruction-fetch interface and the data load/store interface of the core. It sits between the fetch/LSU memory ports and the BRAM model. It grants one outstanding access at a time, using round-robin on contention. It answers out-of-window addresses locally, without touching BRAM.

## Interface
- `base_addr`, default 32'h000000: first byte address served by BRAM.
- `top_addr`, default 32'h100000: first byte address beyond BRAM (exclusive bound).
- `clock`, in, 1: single clock. All state is updated on the rising edge.
- `reset`, in, 1: asynchronous, active-low. Asserting it (0) forces the reset state immediately.
- `imem_valid`, in, 1: fetch request pulse. Address is sampled in the same cycle.
- `imem_addr`, in, 32: fetch byte address.
- `imem_rdata`, out, 32: fetch read data. Meaningful only while `imem_ready`=1.
- `imem_ready`, out, 1: fetch completion pulse.
- `dmem_valid`, in, 1: data request pulse.
- `dmem_addr`, in, 32: data byte address.
- `dmem_wdata`, in, 32: store data.
- `dmem_wstrb`, in, 4: byte write strobes. 0 means load.
- `dmem_rdata`, out, 32: load data.
- `dmem_ready`, out, 1: data completion pulse.
- `bram_valid`, out, 1: backend request pulse (registered).
- `bram_instr`, out, 1: 1 when the current backend access is a fetch.
- `bram_addr`, out, 32: backend address (registered).
- `bram_wdata`, out, 32: backend store data (registered).
- `bram_wstrb`, out, 4: backend strobes. Always 0 for fetches.
- `bram_rdata`, in, 32: backend read data.
- `bram_ready`, in, 1: backend completion pulse. Arrives 1 or more cycles after `bram_valid`.

## Operation
- Each port has a one-deep pending register: valid flag, addr, and for the data port also wdata and wstrb.
  - A `*_valid` pulse is captured when that port has nothing pending or active.
  - A pulse while the port is outstanding is a protocol violation. It is dropped, and the bench asserts it never happens.
- FSM states:
  - IDLE: no access active.
  - ACT_I: fetch active on BRAM.
  - ACT_D: data access active on BRAM.
  - ERR: local error response.
- Selection happens in IDLE, or on the completion cycle of ACT_I/ACT_D/ERR:
  - Candidates are pending entries plus any `*_valid` arriving this cycle.
  - Only one candidate: grant it.
  - Both candidates: grant the port not granted last (`last_grant` flag). After reset, `last_grant` is instruction, so data wins the first tie.
- On grant, the request is checked against the window:
  - In window (`base_addr` <= addr < `top_addr`, unsigned 32-bit compare): register `bram_valid`=1 for one cycle with the request fields, then enter ACT_I or ACT_D.
  - Out of window: enter ERR and issue no backend access.
- ACT_x:
  - Wait for `bram_ready`.
  - In that cycle, `x_ready`=1 and `x_rdata`=`bram_rdata` (combinational pass-through). The pending entry clears.
  - `bram_ready` for the other port is never possible. `bram_ready` while in IDLE is ignored.
- ERR: for one cycle, `x_ready`=1 and `x_rdata`=0. BRAM is untouched.
- A store's `dmem_rdata` is whatever BRAM returns; the requester ignores it.
- Reset mid-access: pending entries, FSM and `last_grant` return to reset values immediately. A late `bram_ready` after reset release is ignored, because the FSM is in IDLE.

## Timing
- Reset values:
  - All outputs are 0: `bram_valid`, `bram_instr`, `bram_addr`, `bram_wdata`, `bram_wstrb`, both readies and both rdatas.
  - FSM=IDLE, pending flags=0, `last_grant`=instruction.
- Request latency: a `*_valid` at cycle t in IDLE gives `bram_valid` at t+1.
- Completion: `x_ready` occurs in the same cycle as `bram_ready`.
- Back-to-back: if the other port is pending when `bram_ready` arrives at cycle c, the next `bram_valid` is at c+1, with zero bubble.
- Out-of-window request at t gives `x_ready` at t+1.
- `bram_valid` is exactly one cycle wide per access.
- Readies are exactly one cycle wide, and there is at most one ready per cycle.

## Structure
- The window defaults come from the `configure` package (`bram_base_addr`, `bram_top_addr`).
- The FSM state enum and grant encoding go in a shared arbiter package, reused by later arbiters for the itim/dtim/clint ports.
- Single module. No sub-module is needed; the per-port pending register is too small to split out.

## Test plan
- Single fetch: `imem_valid` at addr 0x100 at t, BRAM ready 2 cycles later. Required: `bram_valid`/`bram_instr`=1 at t+1, `imem_ready` and `imem_rdata`=BRAM word at t+3.
- Simultaneous requests after reset: fetch 0x0 and store 0x200/0xDEADBEEF/wstrb 4'hF. Required: data is granted first, then the fetch issues the cycle after the data `bram_ready`.
- Continuous contention for 8 accesses: grants strictly alternate D, I, D, I, and no port waits for more than one other access.
- Out-of-window load at 0x1000000: `dmem_ready`=1 and `dmem_rdata`=0 one cycle later, with `bram_valid` never asserted.
- Boundaries: addr 0x0FFFFC is served by BRAM; addr 0x100000 gives an ERR response.
- Reset pulse while in ACT_D: all outputs go to 0 immediately. A subsequent stray `bram_ready` produces no `dmem_ready`. The next fetch completes normally.
